// File: rtl/q_learn_pkg.sv
// Shared grid-world / Q-learning definitions: grid defaults, action and FSM enums,
// and the state-action Q-table address helper used by the environment and the learner.
package q_learn_pkg;

    localparam int unsigned ROWS       = 5;
    localparam int unsigned COLS       = 5;
    localparam int unsigned ACTIONS    = 4;
    localparam int unsigned ADDR_WIDTH = 7;
    localparam int unsigned DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ACT_UP    = 2'd0,
        ACT_DOWN  = 2'd1,
        ACT_LEFT  = 2'd2,
        ACT_RIGHT = 2'd3
    } action_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAND,
        ST_SCAN,
        ST_MOVE,
        ST_OFFER
    } state_e;

    function automatic logic [ADDR_WIDTH-1:0] sa_addr(
        input logic [2:0] row,
        input logic [2:0] col,
        input logic [1:0] action
    );
        int unsigned a;
        a = (32'(row) * COLS + 32'(col)) * ACTIONS + 32'(action);
        return a[ADDR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, advancing one step per enabled cycle.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] state
);

    logic [7:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = {state_q[6:0], state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/gridworld_env_step.sv
// Grid-world environment stage: picks an action, applies wall-clamped moves and reward, offers one
// transition per step over valid/ready. Define EPSILON_GREEDY_EN to build the greedy Q-table scan.
module gridworld_env_step #(
    parameter int unsigned ROWS        = q_learn_pkg::ROWS,
    parameter int unsigned COLS        = q_learn_pkg::COLS,
    parameter int unsigned ACTIONS     = q_learn_pkg::ACTIONS,
    parameter int unsigned ADDR_WIDTH  = q_learn_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = q_learn_pkg::DATA_WIDTH,
    parameter int unsigned START_ROW   = 0,
    parameter int unsigned START_COL   = 0,
    parameter int unsigned GOAL_ROW    = 4,
    parameter int unsigned GOAL_COL    = 4,
    parameter logic [7:0]  GOAL_REWARD = 8'd10,
    parameter logic [7:0]  STEP_REWARD = 8'd0,
    parameter int unsigned MAX_STEPS   = 32,
    parameter logic [7:0]  EPS_THRESH  = 8'd51,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  step_valid,
    input  logic                  step_ready,
    output logic [2:0]            row,
    output logic [2:0]            col,
    output logic [1:0]            action,
    output logic [2:0]            next_row,
    output logic [2:0]            next_col,
    output logic [7:0]            reward,
    output logic                  episode_done,
    output logic [15:0]           episode_count,
    output logic [ADDR_WIDTH-1:0] q_rd_addr,
    input  logic [DATA_WIDTH-1:0] q_rd_data
);
    import q_learn_pkg::*;

    localparam int unsigned STEP_W   = $clog2(MAX_STEPS + 1);
    localparam logic [2:0]  START_R3 = 3'(START_ROW);
    localparam logic [2:0]  START_C3 = 3'(START_COL);
    localparam logic [2:0]  GOAL_R3  = 3'(GOAL_ROW);
    localparam logic [2:0]  GOAL_C3  = 3'(GOAL_COL);
    localparam logic [2:0]  LAST_ROW = 3'(ROWS - 1);
    localparam logic [2:0]  LAST_COL = 3'(COLS - 1);

    state_e              state_q, state_d;
    logic [2:0]          row_q, row_d, col_q, col_d;
    logic [2:0]          next_row_q, next_row_d, next_col_q, next_col_d;
    action_e             action_q, action_d, act_sel_q, act_sel_d;
    logic [7:0]          reward_q, reward_d;
    logic                episode_done_q, episode_done_d;
    logic [15:0]         episode_count_q, episode_count_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d, step_inc;
    logic [2:0]          mv_row, mv_col;
    logic                mv_goal, offer_goal;
    logic                lfsr_en;
    logic [7:0]          lfsr;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (lfsr_en),
        .state (lfsr)
    );

`ifdef EPSILON_GREEDY_EN
    localparam logic [2:0] SCAN_LAST = 3'(ACTIONS);
    logic [2:0]            scan_cnt_q, scan_cnt_d;
    logic [DATA_WIDTH-1:0] best_val_q, best_val_d;
    action_e               best_act_q, best_act_d;
    logic                  explore;

    // Decision uses the LFSR value present on RAND entry; the LFSR steps in the same cycle.
    assign explore = lfsr < EPS_THRESH;

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            best_val_q <= '0;
            best_act_q <= ACT_UP;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            best_val_q <= best_val_d;
            best_act_q <= best_act_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{q_rd_data, lfsr[7:2], EPS_THRESH, 32'(ACTIONS)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            row_q           <= START_R3;
            col_q           <= START_C3;
            next_row_q      <= START_R3;
            next_col_q      <= START_C3;
            action_q        <= ACT_UP;
            act_sel_q       <= ACT_UP;
            reward_q        <= '0;
            episode_done_q  <= 1'b0;
            episode_count_q <= '0;
            step_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            col_q           <= col_d;
            next_row_q      <= next_row_d;
            next_col_q      <= next_col_d;
            action_q        <= action_d;
            act_sel_q       <= act_sel_d;
            reward_q        <= reward_d;
            episode_done_q  <= episode_done_d;
            episode_count_q <= episode_count_d;
            step_cnt_q      <= step_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RAND;
            ST_RAND: begin
`ifdef EPSILON_GREEDY_EN
                state_d = explore ? ST_MOVE : ST_SCAN;
`else
                state_d = ST_MOVE;
`endif
            end
`ifdef EPSILON_GREEDY_EN
            ST_SCAN: if (scan_cnt_q == SCAN_LAST) state_d = ST_MOVE;
`endif
            ST_MOVE:  state_d = ST_OFFER;
            ST_OFFER: if (step_ready) state_d = start ? ST_RAND : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        step_valid = (state_q == ST_OFFER);
        lfsr_en    = (state_q == ST_RAND);
        q_rd_addr  = '0;
`ifdef EPSILON_GREEDY_EN
        if (state_q == ST_SCAN && scan_cnt_q < SCAN_LAST) begin
            q_rd_addr = ADDR_WIDTH'(sa_addr(row_q, col_q, scan_cnt_q[1:0]));
        end
`endif
    end

    always_comb begin
        mv_row = row_q;
        mv_col = col_q;
        unique case (act_sel_q)
            ACT_UP:    if (row_q != '0)      mv_row = row_q - 3'd1;
            ACT_DOWN:  if (row_q != LAST_ROW) mv_row = row_q + 3'd1;
            ACT_LEFT:  if (col_q != '0)      mv_col = col_q - 3'd1;
            ACT_RIGHT: if (col_q != LAST_COL) mv_col = col_q + 3'd1;
        endcase
    end

    assign mv_goal    = (mv_row == GOAL_R3) && (mv_col == GOAL_C3);
    assign offer_goal = (next_row_q == GOAL_R3) && (next_col_q == GOAL_C3);

    always_comb begin
        row_d           = row_q;
        col_d           = col_q;
        next_row_d      = next_row_q;
        next_col_d      = next_col_q;
        action_d        = action_q;
        act_sel_d       = act_sel_q;
        reward_d        = reward_q;
        episode_done_d  = 1'b0;
        episode_count_d = episode_count_q;
        step_cnt_d      = step_cnt_q;
        step_inc        = step_cnt_q + 1'b1;
`ifdef EPSILON_GREEDY_EN
        scan_cnt_d      = scan_cnt_q;
        best_val_d      = best_val_q;
        best_act_d      = best_act_q;
`endif
        unique case (state_q)
            ST_RAND: begin
                act_sel_d = action_e'(lfsr[1:0]);
`ifdef EPSILON_GREEDY_EN
                scan_cnt_d = '0;
`endif
            end
`ifdef EPSILON_GREEDY_EN
            // Data for action k arrives at scan count k+1; strict > keeps ties on the lower index.
            ST_SCAN: begin
                scan_cnt_d = scan_cnt_q + 3'd1;
                if (scan_cnt_q == 3'd1 || (scan_cnt_q != 3'd0 && q_rd_data > best_val_q)) begin
                    best_val_d = q_rd_data;
                    best_act_d = action_e'(scan_cnt_q[1:0] - 2'd1);
                end
                act_sel_d = best_act_d;
            end
`endif
            ST_MOVE: begin
                next_row_d = mv_row;
                next_col_d = mv_col;
                action_d   = act_sel_q;
                reward_d   = mv_goal ? GOAL_REWARD : STEP_REWARD;
            end
            ST_OFFER: begin
                if (step_ready) begin
                    if (offer_goal || step_inc == STEP_W'(MAX_STEPS)) begin
                        episode_done_d  = 1'b1;
                        episode_count_d = episode_count_q + 16'd1;
                        row_d           = START_R3;
                        col_d           = START_C3;
                        step_cnt_d      = '0;
                    end else begin
                        row_d      = next_row_q;
                        col_d      = next_col_q;
                        step_cnt_d = step_inc;
                    end
                end
            end
            default: ;
        endcase
    end

    assign row           = row_q;
    assign col           = col_q;
    assign action        = action_q;
    assign next_row      = next_row_q;
    assign next_col      = next_col_q;
    assign reward        = reward_q;
    assign episode_done  = episode_done_q;
    assign episode_count = episode_count_q;

endmodule

// File: doc/gridworld_env_step.md
# gridworld_env_step

Upstream environment/agent stage for `q_learning_update`. Holds the agent's grid position and picks an action each step: random, or greedy from the Q-table when the epsilon-greedy option is compiled in. It applies grid-world move rules and walls, computes the reward, and offers one transition (row, col, action, next_row, next_col, reward) per step through a valid/ready handshake. Episodes restart from the start cell on reaching the goal or when a step limit expires.

## Interface
- ROWS, 5, grid rows
- COLS, 5, grid columns
- ACTIONS, 4, actions per state (0 up, 1 down, 2 left, 3 right)
- ADDR_WIDTH, 7, Q-table address width
- DATA_WIDTH, 8, Q-value width (unsigned)
- START_ROW / START_COL, 0 / 0, episode start cell
- GOAL_ROW / GOAL_COL, 4 / 4, terminal cell
- GOAL_REWARD, 8'd10, reward on entering goal
- STEP_REWARD, 8'd0, reward on any other move, including wall bumps
- MAX_STEPS, 32, steps per episode before forced restart
- EPS_THRESH, 8'd51, explore when LFSR value < EPS_THRESH
- LFSR_SEED, 8'hA5, nonzero LFSR reset value
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level; while high, steps are generated back-to-back
- step_valid  out  1  transition fields valid
- step_ready  in  1  consumer accepts transition
- row, col  out  3 each  current state
- action  out  2  chosen action
- next_row, next_col  out  3 each  resulting state
- reward  out  8  reward for the transition
- episode_done  out  1  one-cycle pulse on the cycle a terminal/timeout step is accepted
- episode_count  out  16  completed episodes, wraps at 2^16
- q_rd_addr  out  ADDR_WIDTH  Q-table read address
- q_rd_data  in  DATA_WIDTH  read data, valid one cycle after q_rd_addr

## Operation
- Address formula: (row·COLS + col)·ACTIONS + action, computed at ADDR_WIDTH bits. It matches `q_learning_update` addr_sa.
- FSM states: IDLE, RAND, SCAN, MOVE, OFFER.
- IDLE: wait for start=1, then go to RAND.
- RAND: advance the LFSR once. If lfsr<EPS_THRESH, explore: action=lfsr[1:0], go to MOVE. Otherwise go to SCAN.
- SCAN: issue the addresses for actions 0..3 on consecutive cycles, then take the argmax of the returned data. Ties go to the lowest action index. Then go to MOVE.
- MOVE: compute the next cell.
  - Up/left at row/col 0 is clamped; down/right at ROWS-1/COLS-1 is clamped. A clamped move leaves the next cell equal to the current cell.
  - reward = GOAL_REWARD if next == goal, else STEP_REWARD.
  - Register all transition outputs, then go to OFFER.
- OFFER: hold step_valid=1 with all fields stable until step_ready=1. On acceptance:
  - step counter increments.
  - If next==goal or the counter reached MAX_STEPS: pulse episode_done, increment episode_count, reset position to start, clear the step counter.
  - Otherwise row/col take next_row/next_col.
  - Then go to RAND if start=1, else IDLE.
- start falling mid-step does not abort the step; the FSM finishes in OFFER and then goes to IDLE.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Seed loaded on rst, so it is never zero.
- A start cell equal to the goal cell is legal; the episode ends only after a move is accepted.

## Timing
- Reset values:
  - step_valid=0, episode_done=0, episode_count=0, q_rd_addr=0.
  - row/col=START, next_row/next_col=START, action=0, reward=0.
  - FSM=IDLE, step counter=0, lfsr=LFSR_SEED.
- rst in any state, including mid-SCAN or while step_valid=1, returns to IDLE on the next edge. Any transition in progress is dropped.
- Explore path: RAND, then MOVE; step_valid rises 2 cycles after RAND entry.
- Exploit path:
  - RAND (1 cycle), then SCAN (5 cycles: addresses on cycles 0..3, data compared on cycles 1..4), then MOVE.
  - step_valid rises 7 cycles after RAND entry.
- Handshake completes on a cycle with step_valid&step_ready.
- With start=1 and step_ready tied high, the next RAND follows in the cycle after the handshake.
- episode_done is high only in the cycle after acceptance; episode_count updates in the same cycle.

## Configuration
- EPSILON_GREEDY_EN defined: full behaviour above; SCAN is reachable and q_rd_addr is driven.
- EPSILON_GREEDY_EN undefined:
  - Always explore: RAND goes directly to MOVE and SCAN is not built.
  - q_rd_addr is held at 0 and q_rd_data is ignored; EPS_THRESH has no effect.

## Structure
- q_learn_pkg holds:
  - the action enum (ACT_UP, ACT_DOWN, ACT_LEFT, ACT_RIGHT);
  - the state enum;
  - an sa_addr(row,col,action) function;
  - shared grid defaults (ROWS, COLS, ACTIONS, ADDR_WIDTH, DATA_WIDTH).
- q_learning_update imports the same package.
- Sub-module lfsr8: seed parameter, enable, 8-bit state output.

## Test plan
- Reset: hold rst 3 cycles with start=1. Expect all outputs at reset values, step_valid=0, lfsr=8'hA5.
- Wall clamp (macro off, position forced to 0,0, LFSR yielding action 0): expect next=(0,0), reward=0, step_valid=1, 2 cycles after RAND.
- Goal (macro off, at (4,3), action 3): expect next=(4,4) and reward=10. On accept: episode_done pulses for 1 cycle, episode_count=1, row/col=(0,0).
- Backpressure: step_ready low for 5 cycles during OFFER. Expect all fields stable and no step counting; accepted on the 6th cycle.
- Greedy (macro on, EPS_THRESH=0, Q for the current state=[3,9,9,1]):
  - q_rd_addr walks base+0..3;
  - action=1 (tie goes to the lower index);
  - step_valid 7 cycles after RAND.
- Timeout and reset (MAX_STEPS=4, goal unreachable): after the 4th accepted step, episode_done=1 and position returns to start. Then assert rst mid-SCAN: expect IDLE and step_valid=0 next cycle.
